// File: rtl/inst_fetch_pkg.sv
// inst_fetch_pkg: shared widths, reset pc, fsm states and buffer entry layout for the fetch unit
package inst_fetch_pkg;
  localparam int BR_WD = 33;
  localparam int PAIR_WD = 96;
  localparam logic [31:0] DEF_RESET_PC = 32'hbfc0_0000;
  typedef enum logic [1:0] {
    S_REQ    = 2'd0,
    S_WAIT   = 2'd1,
    S_CANCEL = 2'd2
  } fetch_state_e;
  typedef struct packed {
    logic [31:0] pc;
    logic [63:0] inst;
  } fetch_pair_t;
  function automatic logic [31:0] pair_base(input logic [31:0] pc);
    return {pc[31:3], 3'b000};
  endfunction
endpackage

// File: rtl/inst_fetch_fifo.sv
// inst_fetch_fifo: fetch-pair buffer with flush; head is read from storage registers, zero when empty
module inst_fetch_fifo
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = PAIR_WD
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush_i,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic [WIDTH-1:0]               din_i,
  output logic                           valid_o,
  output logic [WIDTH-1:0]               dout_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign do_pop = pop_i && cnt_q != '0;
  assign do_push = push_i && (cnt_q != CW'(DEPTH) || do_pop);
  assign valid_o = cnt_q != '0;
  assign dout_o = valid_o ? mem_q[rd_q] : '0;
  assign count_o = cnt_q;
  // storage write, no reset needed since the head is masked while empty
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
  // pointers and occupancy; flush empties the buffer and overrides push/pop
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/inst_fetch.sv
// inst_fetch: issues aligned pair fetches, tracks one outstanding request, buffers returned pairs
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BR_WD-1:0] br_bus,
  input  logic             stall,
  output logic             inst_req,
  output logic [31:0]      inst_addr,
  input  logic             inst_addr_ok,
  input  logic             inst_data_ok,
  input  logic [63:0]      inst_rdata,
  output logic             fetch_valid,
  output logic [31:0]      fetch_pc,
  output logic [63:0]      fetch_inst
);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  fetch_state_e state_q;
  logic [31:0] pc_q, tag_q;
  logic [CW-1:0] count;
  logic br_e, accept, push, pop;
  fetch_pair_t head;
  assign br_e = br_bus[32];
  assign inst_addr = pair_base(pc_q);
  assign inst_req = state_q == S_REQ && count < CW'(FIFO_DEPTH);
  assign accept = inst_req && inst_addr_ok;
  assign push = state_q == S_WAIT && inst_data_ok && !br_e;
  assign pop = fetch_valid && !stall && !br_e;
  assign fetch_pc = head.pc;
  assign fetch_inst = head.inst;
  // fetch fsm with pc and request tag; a redirect cancels any in-flight response
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      tag_q   <= '0;
    end else begin
      pc_q    <= br_e ? br_bus[31:0] : accept ? pair_base(pc_q) + 32'd8 : pc_q;
      tag_q   <= accept ? pc_q : tag_q;
      state_q <= state_q == S_REQ ? (accept ? (br_e ? S_CANCEL : S_WAIT) : S_REQ)
               : inst_data_ok ? S_REQ
               : br_e ? S_CANCEL : state_q;
    end
  end
  inst_fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PAIR_WD)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .flush_i(br_e),
    .push_i (push),
    .pop_i  (pop),
    .din_i  ({tag_q, inst_rdata}),
    .valid_o(fetch_valid),
    .dout_o (head),
    .count_o(count)
  );
endmodule
